// File: rtl/udp_tx_frame_scheduler_pkg.sv
// Shared widths, FSM encoding and the forwarded-beat payload for the UDP TX frame scheduler.
package udp_tx_frame_scheduler_pkg;

    localparam int unsigned CH_MAX = 8;
    localparam int unsigned IDX_W  = $clog2(CH_MAX);
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned PORT_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              valid;
    } udp_beat_t;

endpackage

// File: rtl/udp_tx_frame_scheduler_if.sv
// Source-side request/byte bus plus stack-side send bus of the UDP TX frame scheduler.
interface udp_tx_frame_scheduler_if
    import udp_tx_frame_scheduler_pkg::*;
#(
    parameter int unsigned P_CH = 4
);
    logic [P_CH-1:0]        i_req;
    logic [LEN_W*P_CH-1:0]  i_len;
    logic [PORT_W*P_CH-1:0] i_dst_port;
    logic [DATA_W*P_CH-1:0] i_data;
    logic [P_CH-1:0]        i_valid;
    logic [P_CH-1:0]        i_last;
    logic [P_CH-1:0]        o_gnt;
    logic                   i_stack_ready;
    logic [DATA_W-1:0]      o_udp_data;
    logic [LEN_W-1:0]       o_udp_len;
    logic                   o_udp_last;
    logic                   o_udp_valid;
    logic [PORT_W-1:0]      o_dst_port;
    logic                   o_dst_valid;
    logic                   o_len_err;
    logic                   o_timeout;

    modport master (
        input  i_req, i_len, i_dst_port, i_data, i_valid, i_last, i_stack_ready,
        output o_gnt, o_udp_data, o_udp_len, o_udp_last, o_udp_valid,
               o_dst_port, o_dst_valid, o_len_err, o_timeout
    );

    modport slave (
        output i_req, i_len, i_dst_port, i_data, i_valid, i_last, i_stack_ready,
        input  o_gnt, o_udp_data, o_udp_len, o_udp_last, o_udp_valid,
               o_dst_port, o_dst_valid, o_len_err, o_timeout
    );
endinterface

// File: rtl/udp_tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, as one-hot plus index.
module rr_arbiter_onehot
    import udp_tx_frame_scheduler_pkg::*;
#(
    parameter int unsigned P_CH = 4
) (
    input  logic [P_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [P_CH-1:0]  gnt_c,
    output logic [IDX_W-1:0] idx_c
);
    int unsigned pos;
    logic        found;

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < P_CH; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= P_CH) pos = pos - P_CH;
            for (int unsigned j = 0; j < P_CH; j++) begin
                if (!found && pos == j && req[j]) begin
                    gnt_c[j] = 1'b1;
                    idx_c    = IDX_W'(j);
                    found    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/udp_tx_frame_scheduler.sv
// Frame-level round-robin scheduler: one source owns the UDP stack send port per frame,
// bytes forwarded with one registered cycle, length/timeout/gap enforced.
module udp_tx_frame_scheduler
    import udp_tx_frame_scheduler_pkg::*;
#(
    parameter int unsigned P_CH          = 4,
    parameter int unsigned P_GAP         = 12,
    parameter int unsigned P_GNT_TIMEOUT = 256
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    udp_tx_frame_scheduler_if.master bus
);
    localparam int unsigned TMR_W = (P_GNT_TIMEOUT > 2) ? $clog2(P_GNT_TIMEOUT) : 1;
    localparam int unsigned GAP_W = (P_GAP > 2) ? $clog2(P_GAP) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ch_q, ch_d, ptr_q, ptr_d;
    logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d, cnt_inc;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                drop_q, drop_d;
    logic [P_CH-1:0]     gnt_q, gnt_d;
    udp_beat_t           beat_q, beat_d;
    logic [LEN_W-1:0]    udp_len_q, udp_len_d;
    logic [PORT_W-1:0]   dst_port_q, dst_port_d;
    logic                dst_valid_q, dst_valid_d;
    logic                len_err_q, len_err_d;
    logic                timeout_q, timeout_d;
    logic                frame_done;

    logic [P_CH-1:0]     arb_gnt_c;
    logic [IDX_W-1:0]    arb_idx_c;
    logic                sel_valid_c, sel_last_c;
    logic [DATA_W-1:0]   sel_data_c;
    logic [LEN_W-1:0]    arb_len_c;
    logic [PORT_W-1:0]   arb_port_c;

    rr_arbiter_onehot #(.P_CH(P_CH)) u_arb (
        .req   (bus.i_req),
        .ptr   (ptr_q),
        .gnt_c (arb_gnt_c),
        .idx_c (arb_idx_c)
    );

    // Granted-channel byte lanes and the to-be-granted channel's frame parameters
    always_comb begin
        sel_valid_c = 1'b0;
        sel_last_c  = 1'b0;
        sel_data_c  = '0;
        arb_len_c   = '0;
        arb_port_c  = '0;
        for (int unsigned i = 0; i < P_CH; i++) begin
            if (ch_q == IDX_W'(i)) begin
                sel_valid_c = bus.i_valid[i];
                sel_last_c  = bus.i_last[i];
                sel_data_c  = bus.i_data[i*DATA_W +: DATA_W];
            end
            if (arb_idx_c == IDX_W'(i)) begin
                arb_len_c  = bus.i_len[i*LEN_W +: LEN_W];
                arb_port_c = bus.i_dst_port[i*PORT_W +: PORT_W];
            end
        end
    end

    assign cnt_inc = cnt_q + LEN_W'(1);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        gap_d       = gap_q;
        drop_d      = drop_q;
        gnt_d       = gnt_q;
        beat_d      = '0;
        udp_len_d   = udp_len_q;
        dst_port_d  = dst_port_q;
        dst_valid_d = 1'b0;
        len_err_d   = 1'b0;
        timeout_d   = 1'b0;
        frame_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                udp_len_d = '0;
                if ((|bus.i_req) && bus.i_stack_ready) begin
                    state_d     = ST_GRANT;
                    ch_d        = arb_idx_c;
                    gnt_d       = arb_gnt_c;
                    ptr_d       = (arb_idx_c == IDX_W'(P_CH - 1)) ? '0 : arb_idx_c + IDX_W'(1);
                    len_d       = (arb_len_c == '0) ? LEN_W'(1) : arb_len_c;
                    udp_len_d   = (arb_len_c == '0) ? LEN_W'(1) : arb_len_c;
                    dst_port_d  = arb_port_c;
                    dst_valid_d = 1'b1;
                    cnt_d       = '0;
                    tmr_d       = '0;
                    drop_d      = 1'b0;
                end
            end
            ST_GRANT, ST_XFER: begin
                if (sel_valid_c && drop_q) begin
                    // Overlong frame already closed; swallow bytes until the source ends it
                    if (sel_last_c) begin
                        gnt_d      = '0;
                        frame_done = 1'b1;
                    end
                end else if (sel_valid_c) begin
                    state_d     = ST_XFER;
                    beat_d.valid = 1'b1;
                    beat_d.data  = sel_data_c;
                    cnt_d        = cnt_inc;
                    if (sel_last_c) begin
                        beat_d.last = 1'b1;
                        len_err_d   = (cnt_inc != len_q);
                        gnt_d       = '0;
                        frame_done  = 1'b1;
                    end else if (cnt_inc == len_q) begin
                        beat_d.last = 1'b1;
                        len_err_d   = 1'b1;
                        drop_d      = 1'b1;
                    end
                end else if (state_q == ST_GRANT) begin
                    if (tmr_q == TMR_W'(P_GNT_TIMEOUT - 1)) begin
                        gnt_d      = '0;
                        timeout_d  = 1'b1;
                        frame_done = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            ST_GAP: begin
                udp_len_d = '0;
                if (gap_q == GAP_W'(P_GAP - 1)) state_d = ST_IDLE;
                else                            gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_done) begin
            state_d = (P_GAP == 0) ? ST_IDLE : ST_GAP;
            gap_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            ptr_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            gap_q       <= '0;
            drop_q      <= 1'b0;
            gnt_q       <= '0;
            beat_q      <= '0;
            udp_len_q   <= '0;
            dst_port_q  <= '0;
            dst_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            gap_q       <= gap_d;
            drop_q      <= drop_d;
            gnt_q       <= gnt_d;
            beat_q      <= beat_d;
            udp_len_q   <= udp_len_d;
            dst_port_q  <= dst_port_d;
            dst_valid_q <= dst_valid_d;
            len_err_q   <= len_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.o_gnt       = gnt_q;
    assign bus.o_udp_data  = beat_q.data;
    assign bus.o_udp_last  = beat_q.last;
    assign bus.o_udp_valid = beat_q.valid;
    assign bus.o_udp_len   = udp_len_q;
    assign bus.o_dst_port  = dst_port_q;
    assign bus.o_dst_valid = dst_valid_q;
    assign bus.o_len_err   = len_err_q;
    assign bus.o_timeout   = timeout_q;
endmodule
